// File: rtl/serial_au.sv
// serial_au: bit-serial adder/subtractor, one full-adder step per clock, LSB first.
// Valid/ready request and result handshakes around an IDLE/RUN/DONE controller.
module serial_au #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_next;

  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             sum_bit;
  logic             carry_next;

  assign sum_bit    = a_q[0] ^ b_q[0] ^ carry;
  assign carry_next = (a_q[0] & b_q[0]) | ((a_q[0] ^ b_q[0]) & carry);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (cnt == LAST) state_next = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // B is stored pre-inverted with carry-in = sub, so subtraction is A + ~B + 1.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_q   <= '0;
      b_q   <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      s     <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_q   <= a;
            b_q   <= b ^ {WIDTH{sub}};
            carry <= sub;
            cnt   <= '0;
          end
        end
        RUN: begin
          s     <= {sum_bit, s[WIDTH-1:1]};
          a_q   <= a_q >> 1;
          b_q   <= b_q >> 1;
          carry <= carry_next;
          cnt   <= cnt + CW'(1);
          // On the last step the operand LSBs are the captured MSBs.
          if (cnt == LAST) begin
            cout <= carry_next;
            ovf  <= (a_q[0] == b_q[0]) && (sum_bit != a_q[0]);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_au.sv
// tb_serial_au: scoreboard bench for serial_au at WIDTH=4.
// Expected results are queued when a request is driven and popped when a result appears.
module tb_serial_au;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         sub = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] s;
  logic         cout;
  logic         ovf;
  logic         busy;

  typedef struct packed {
    logic [W-1:0] s;
    logic         cout;
    logic         ovf;
  } res_t;

  res_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  serial_au #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .s         (s),
    .cout      (cout),
    .ovf       (ovf),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Arithmetic reference: (a +/- b) mod 2^W, carry out, signed overflow.
  function automatic res_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic sb);
    logic [W-1:0] yy;
    logic [W:0]   sum;
    res_t         r;
    yy    = sb ? ~y : y;
    sum   = {1'b0, x} + {1'b0, yy} + {{W{1'b0}}, sb};
    r.s   = sum[W-1:0];
    r.cout = sum[W];
    r.ovf = (x[W-1] == yy[W-1]) && (r.s[W-1] != x[W-1]);
    return r;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Drives one request and queues its expected result; returns just after the accepting edge.
  task automatic send(input logic [W-1:0] x, input logic [W-1:0] y, input logic sb, input res_t e);
    int n;
    n = 0;
    while (!in_ready && n < 20) begin
      tick();
      n++;
    end
    a        = x;
    b        = y;
    sub      = sb;
    in_valid = 1'b1;
    exp_q.push_back(e);
    tick();
    in_valid = 1'b0;
  endtask

  // Counts edges until out_valid is seen; saturates at 50.
  task automatic wait_done(output int n);
    n = 0;
    while (!out_valid && n < 50) begin
      tick();
      n++;
    end
  endtask

  task automatic test_reset;
    rst_n     = 1'b0;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    a         = 4'b0101;
    b         = 4'b0011;
    tick();
    tick();
    total++;
    if ({in_ready, out_valid, busy} !== 3'b100) begin
      bad++;
      $display("FAIL reset_ctrl: in_ready/out_valid/busy=%b want 100", {in_ready, out_valid, busy});
    end
    total++;
    if ({s, cout, ovf} !== '0) begin
      bad++;
      $display("FAIL reset_data: s=%b cout=%b ovf=%b want all 0", s, cout, ovf);
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    rst_n     = 1'b1;
    tick();
    total++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_release: in_ready=%b busy=%b want 1 0", in_ready, busy);
    end
  endtask

  task automatic test_vectors;
    logic [W-1:0] va[5] = '{4'b0011, 4'b1111, 4'b0101, 4'b0011, 4'b1000};
    logic [W-1:0] vb[5] = '{4'b0101, 4'b0001, 4'b0011, 4'b0101, 4'b0001};
    logic         vs[5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    res_t         ve[5] = '{6'b1000_0_1, 6'b0000_1_0, 6'b0010_1_0, 6'b1110_0_0, 6'b0111_1_1};
    res_t         e;
    int           n;
    for (int k = 0; k < 5; k++) begin
      send(va[k], vb[k], vs[k], ve[k]);
      wait_done(n);
      total++;
      if (n !== W) begin
        bad++;
        $display("FAIL vec%0d_latency: edges=%0d want %0d", k, n, W);
      end
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL vec%0d_result: scoreboard empty", k);
      end else begin
        e = exp_q.pop_front();
        if ({s, cout, ovf} !== e) begin
          bad++;
          $display("FAIL vec%0d_result: s=%b cout=%b ovf=%b want s=%b cout=%b ovf=%b",
                   k, s, cout, ovf, e.s, e.cout, e.ovf);
        end
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      total++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
        bad++;
        $display("FAIL vec%0d_return: in_ready=%b out_valid=%b want 1 0", k, in_ready, out_valid);
      end
    end
  endtask

  task automatic test_backpressure;
    res_t e;
    int   n;
    send(4'b0110, 4'b0011, 1'b0, model(4'b0110, 4'b0011, 1'b0));
    e = exp_q.pop_front();
    n = 0;
    while (!out_valid && n < 50) begin
      in_valid = 1'b1;
      a        = W'($urandom);
      b        = W'($urandom);
      sub      = 1'($urandom);
      tick();
      n++;
    end
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'(k);
      a        = W'($urandom);
      b        = W'($urandom);
      tick();
      total++;
      if ({out_valid, s, cout, ovf} !== {1'b1, e}) begin
        bad++;
        $display("FAIL hold%0d: out_valid=%b s=%b cout=%b ovf=%b want 1 s=%b cout=%b ovf=%b",
                 k, out_valid, s, cout, ovf, e.s, e.cout, e.ovf);
      end
    end
    // Handshake edge with a request pending: the request must not be taken.
    in_valid  = 1'b1;
    out_ready = 1'b1;
    tick();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    total++;
    if ({in_ready, out_valid, busy} !== 3'b100) begin
      bad++;
      $display("FAIL bp_return: in_ready/out_valid/busy=%b want 100", {in_ready, out_valid, busy});
    end
  endtask

  task automatic test_reset_abort;
    res_t e;
    int   n;
    send(4'b0111, 4'b0110, 1'b0, model(4'b0111, 4'b0110, 1'b0));
    void'(exp_q.pop_back());
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    total++;
    if ({in_ready, out_valid, busy, s, cout, ovf} !== {3'b100, {(W + 2){1'b0}}}) begin
      bad++;
      $display("FAIL abort: in_ready=%b out_valid=%b busy=%b s=%b cout=%b ovf=%b want 1 0 0 0 0 0",
               in_ready, out_valid, busy, s, cout, ovf);
    end
    send(4'b0001, 4'b0001, 1'b0, 6'b0010_0_0);
    wait_done(n);
    total++;
    if (exp_q.size() == 0 || n >= 50) begin
      bad++;
      $display("FAIL post_abort: no result (edges=%0d)", n);
    end else begin
      e = exp_q.pop_front();
      if ({s, cout, ovf} !== e) begin
        bad++;
        $display("FAIL post_abort: s=%b cout=%b ovf=%b want s=%b cout=%b ovf=%b",
                 s, cout, ovf, e.s, e.cout, e.ovf);
      end
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_back_to_back;
    logic [8:0] idx;
    res_t       e;
    int         i, got, cyc, last_acc;
    logic       acc;
    i        = 0;
    got      = 0;
    cyc      = 0;
    last_acc = -1;
    idx      = '0;
    a        = idx[3:0];
    b        = idx[7:4];
    sub      = idx[8];
    in_valid  = 1'b1;
    out_ready = 1'b1;
    while (got < 512 && cyc < 6000) begin
      if (out_valid) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL b2b_result: unexpected result s=%b", s);
        end else begin
          e = exp_q.pop_front();
          if ({s, cout, ovf} !== e) begin
            bad++;
            $display("FAIL b2b_result%0d: s=%b cout=%b ovf=%b want s=%b cout=%b ovf=%b",
                     got, s, cout, ovf, e.s, e.cout, e.ovf);
          end
        end
        got++;
      end
      acc = in_ready && in_valid;
      if (acc) begin
        exp_q.push_back(model(a, b, sub));
        if (last_acc >= 0) begin
          total++;
          if (cyc - last_acc != W + 2) begin
            bad++;
            $display("FAIL b2b_period: gap=%0d want %0d", cyc - last_acc, W + 2);
          end
        end
        last_acc = cyc;
        i++;
      end
      tick();
      cyc++;
      if (acc) begin
        if (i < 512) begin
          idx = 9'(i);
          a   = idx[3:0];
          b   = idx[7:4];
          sub = idx[8];
        end else begin
          in_valid = 1'b0;
        end
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    total++;
    if (got != 512 || exp_q.size() != 0) begin
      bad++;
      $display("FAIL b2b_count: results=%0d pending=%0d want 512 0", got, exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_backpressure();
    test_reset_abort();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
